// File: rtl/hdmi_timing_if.sv
// Video timing bundle from the raster generator to the pattern/ROM stage.
// loc_x/loc_y/frame_start are undelayed; hsync/vsync/de are pre-delayed to
// line up with the colour produced by that stage.
interface hdmi_timing_if;
  logic [11:0] loc_x;
  logic [11:0] loc_y;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        frame_start;

  modport master (
    output loc_x,
    output loc_y,
    output hsync,
    output vsync,
    output de,
    output frame_start
  );

  modport slave (
    input loc_x,
    input loc_y,
    input hsync,
    input vsync,
    input de,
    input frame_start
  );
endinterface

// File: rtl/hdmi_timing_gen.sv
// Raster timing generator (default 1280x720@60). Free-running h/v counters
// are decoded and registered once; coordinates and frame_start leave after
// that register, while the sync/de decodes pass a further PIPE_DLY stages
// so they arrive together with the downstream colour data.
// Handshake: none -- every output is a registered level that is valid on
// every clock; the consumer samples it on clk_in with no back-pressure.
module hdmi_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PIPE_DLY = 2     // legal range 0..8
) (
  input  logic          clk_in,
  input  logic          reset,
  hdmi_timing_if.master vid
);

  localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_ACT_START = H_SYNC + H_BP;
  localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int V_ACT_START = V_SYNC + V_BP;
  localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        h_wrap;

  logic        hs_raw, vs_raw, h_act, v_act, de_raw, fs_raw;
  logic [11:0] loc_x_d, loc_y_d;

  logic [11:0] loc_x_q, loc_y_q;
  logic        hs_q, vs_q, de_q, fs_q;

  logic        hs_dly, vs_dly, de_dly;

  // Counter next-state: h every clock, v only on the h wrap.
  always_comb begin
    h_wrap  = (h_cnt_q == 12'(H_TOTAL - 1));
    h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == 12'(V_TOTAL - 1)) ? 12'd0 : v_cnt_q + 12'd1;
    end
  end

  // Counter registers; reset restarts the raster at (0,0).
  always_ff @(posedge clk_in) begin
    if (reset) begin
      h_cnt_q <= 12'd0;
      v_cnt_q <= 12'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Position decode: sync first, then back porch, active, front porch.
  always_comb begin
    hs_raw  = (h_cnt_q < 12'(H_SYNC));
    vs_raw  = (v_cnt_q < 12'(V_SYNC));
    h_act   = (h_cnt_q >= 12'(H_ACT_START)) && (h_cnt_q < 12'(H_ACT_END));
    v_act   = (v_cnt_q >= 12'(V_ACT_START)) && (v_cnt_q < 12'(V_ACT_END));
    de_raw  = h_act && v_act;
    fs_raw  = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    loc_x_d = h_act ? (h_cnt_q - 12'(H_ACT_START)) : 12'hFFF;
    loc_y_d = v_act ? (v_cnt_q - 12'(V_ACT_START)) : 12'hFFF;
  end

  // First output register stage: coordinates, frame pulse, raw sync/de.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      loc_x_q <= 12'hFFF;
      loc_y_q <= 12'hFFF;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      loc_x_q <= loc_x_d;
      loc_y_q <= loc_y_d;
      hs_q    <= hs_raw;
      vs_q    <= vs_raw;
      de_q    <= de_raw;
      fs_q    <= fs_raw;
    end
  end

  // Extra delay on sync/de to cover the downstream address+ROM latency.
  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign hs_dly = hs_q;
      assign vs_dly = vs_q;
      assign de_dly = de_q;
    end else begin : g_dly
      logic [2:0] pipe_q [PIPE_DLY];

      // Shift {hs,vs,de} through PIPE_DLY stages; cleared on reset.
      always_ff @(posedge clk_in) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DLY; i++) pipe_q[i] <= 3'b000;
        end else begin
          pipe_q[0] <= {hs_q, vs_q, de_q};
          for (int i = 1; i < PIPE_DLY; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign {hs_dly, vs_dly, de_dly} = pipe_q[PIPE_DLY-1];
    end
  endgenerate

  // Internal syncs are active-high; polarity is applied only at the pins.
  assign vid.hsync       = HS_POL ? hs_dly : ~hs_dly;
  assign vid.vsync       = VS_POL ? vs_dly : ~vs_dly;
  assign vid.de          = de_dly;
  assign vid.loc_x       = loc_x_q;
  assign vid.loc_y       = loc_y_q;
  assign vid.frame_start = fs_q;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen. Instance A uses the 720p defaults (PIPE_DLY=2,
// active-high syncs) and covers the first 27 lines after reset. Instance B
// is a shrunken raster (28x13 clocks/lines, PIPE_DLY=0, active-low syncs)
// so whole frames and a mid-frame reset fit in a short run.
module tb_hdmi_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  hdmi_timing_if vid_a ();
  hdmi_timing_if vid_b ();

  hdmi_timing_gen dut_a (
    .clk_in (clk),
    .reset  (rst_a),
    .vid    (vid_a)
  );

  hdmi_timing_gen #(
    .H_ACTIVE (16), .H_FP (3), .H_SYNC (4), .H_BP (5),
    .V_ACTIVE (6),  .V_FP (2), .V_SYNC (2), .V_BP (3),
    .HS_POL   (1'b0), .VS_POL (1'b0), .PIPE_DLY (0)
  ) dut_b (
    .clk_in (clk),
    .reset  (rst_b),
    .vid    (vid_b)
  );

  // ---------------- bookkeeping ----------------
  int test_cnt = 0;
  int fail_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    test_cnt++;
    assert (obs === exp_v) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  // Advance one clock and sample 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Small raster: H 28 (sync 0..3, active 9..24), V 13 (sync 0..1, active 5..10).
  // k counts clocks since reset release; the value shown at k decodes
  // counter position k-1 (no extra delay on sync/de).
  task automatic run_small(input int nfr, input string tag);
    int h, v, i;
    int fs_cnt, fs_first, fs_last;
    int bad_x, bad_y, bad_de, bad_hs, bad_vs, bad_align;
    int de_cnt, hs_low, vs_low, max_x, max_y;
    logic [11:0] ex, ey;
    logic ede, ehs, evs;
    fs_cnt = 0; fs_first = 0; fs_last = 0;
    bad_x = 0; bad_y = 0; bad_de = 0; bad_hs = 0; bad_vs = 0; bad_align = 0;
    de_cnt = 0; hs_low = 0; vs_low = 0; max_x = 0; max_y = 0;
    for (int k = 1; k <= nfr * 364; k++) begin
      tick();
      i   = k - 1;
      h   = i % 28;
      v   = (i / 28) % 13;
      ex  = (h >= 9 && h < 25) ? 12'(h - 9) : 12'hFFF;
      ey  = (v >= 5 && v < 11) ? 12'(v - 5) : 12'hFFF;
      ede = (h >= 9 && h < 25) && (v >= 5 && v < 11);
      ehs = !(h < 4);
      evs = !(v < 2);
      if (vid_b.loc_x !== ex)  bad_x++;
      if (vid_b.loc_y !== ey)  bad_y++;
      if (vid_b.de    !== ede) bad_de++;
      if (vid_b.hsync !== ehs) bad_hs++;
      if (vid_b.vsync !== evs) bad_vs++;
      if (vid_b.de !== ((vid_b.loc_x != 12'hFFF) && (vid_b.loc_y != 12'hFFF))) bad_align++;
      if (vid_b.frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_first == 0) fs_first = k;
        fs_last = k;
      end
      if (vid_b.de === 1'b1)    de_cnt++;
      if (vid_b.hsync === 1'b0) hs_low++;
      if (vid_b.vsync === 1'b0) vs_low++;
      if (vid_b.loc_x != 12'hFFF && int'(vid_b.loc_x) > max_x) max_x = int'(vid_b.loc_x);
      if (vid_b.loc_y != 12'hFFF && int'(vid_b.loc_y) > max_y) max_y = int'(vid_b.loc_y);
    end
    check({tag, "_fs_cnt"},   fs_cnt, nfr);
    check({tag, "_fs_first"}, fs_first, 1);
    check({tag, "_fs_last"},  fs_last, 1 + (nfr - 1) * 364);
    check({tag, "_locx_bad"}, bad_x, 0);
    check({tag, "_locy_bad"}, bad_y, 0);
    check({tag, "_de_bad"},   bad_de, 0);
    check({tag, "_hs_bad"},   bad_hs, 0);
    check({tag, "_vs_bad"},   bad_vs, 0);
    check({tag, "_de_align"}, bad_align, 0);
    check({tag, "_de_cnt"},   de_cnt, 96 * nfr);
    check({tag, "_hs_low"},   hs_low, 52 * nfr);
    check({tag, "_vs_low"},   vs_low, 56 * nfr);
    check({tag, "_max_x"},    max_x, 15);
    check({tag, "_max_y"},    max_y, 5);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int h, v, hd, vd, i;
    int fs_cnt, fs_first, hs_cnt, hs_first, vs_cnt;
    int de_cnt, de_rise, de_fall, lx0_k, max_x, max_y;
    int bad_x, bad_y, bad_de, bad_hs, bad_vs;
    logic prev_de;
    logic [11:0] ex, ey;
    logic ede, ehs, evs;

    // Reset values of both instances.
    repeat (3) tick();
    check("a_rst_locx",  vid_a.loc_x, 12'hFFF);
    check("a_rst_locy",  vid_a.loc_y, 12'hFFF);
    check("a_rst_de",    vid_a.de, 1'b0);
    check("a_rst_hsync", vid_a.hsync, 1'b0);
    check("a_rst_vsync", vid_a.vsync, 1'b0);
    check("a_rst_fs",    vid_a.frame_start, 1'b0);
    check("b_rst_hsync", vid_b.hsync, 1'b1);
    check("b_rst_vsync", vid_b.vsync, 1'b1);
    check("b_rst_de",    vid_b.de, 1'b0);

    // Instance A: 27 lines of 720p after release.
    // loc at clock k decodes position k-1; sync/de decode position k-3.
    rst_a = 1'b0;
    fs_cnt = 0; fs_first = 0; hs_cnt = 0; hs_first = 0; vs_cnt = 0;
    de_cnt = 0; de_rise = 0; de_fall = 0; lx0_k = 0; max_x = 0; max_y = 0;
    bad_x = 0; bad_y = 0; bad_de = 0; bad_hs = 0; bad_vs = 0;
    prev_de = 1'b0;
    for (int k = 1; k <= 27 * 1650; k++) begin
      tick();
      i  = k - 1;
      h  = i % 1650;
      v  = i / 1650;
      ex = (h >= 260 && h < 1540) ? 12'(h - 260) : 12'hFFF;
      ey = (v >= 25 && v < 745) ? 12'(v - 25) : 12'hFFF;
      if (k >= 3) begin
        hd  = (k - 3) % 1650;
        vd  = (k - 3) / 1650;
        ehs = (hd < 40);
        evs = (vd < 5);
        ede = (hd >= 260 && hd < 1540) && (vd >= 25 && vd < 745);
      end else begin
        ehs = 1'b0; evs = 1'b0; ede = 1'b0;
      end
      if (vid_a.loc_x !== ex)  bad_x++;
      if (vid_a.loc_y !== ey)  bad_y++;
      if (vid_a.hsync !== ehs) bad_hs++;
      if (vid_a.vsync !== evs) bad_vs++;
      if (vid_a.de    !== ede) bad_de++;
      if (vid_a.frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_first == 0) fs_first = k;
      end
      if (k <= 1650 && vid_a.hsync === 1'b1) begin
        hs_cnt++;
        if (hs_first == 0) hs_first = k;
      end
      if (vid_a.vsync === 1'b1) vs_cnt++;
      if (vid_a.de === 1'b1) de_cnt++;
      if (!prev_de && vid_a.de === 1'b1 && de_rise == 0) de_rise = k;
      if (prev_de && vid_a.de === 1'b0 && de_fall == 0) de_fall = k;
      prev_de = (vid_a.de === 1'b1);
      if (vid_a.loc_x == 12'd0 && vid_a.loc_y == 12'd0 && lx0_k == 0) lx0_k = k;
      if (vid_a.loc_x != 12'hFFF && int'(vid_a.loc_x) > max_x) max_x = int'(vid_a.loc_x);
      if (vid_a.loc_y != 12'hFFF && int'(vid_a.loc_y) > max_y) max_y = int'(vid_a.loc_y);
    end
    check("a_fs_cnt",    fs_cnt, 1);
    check("a_fs_first",  fs_first, 1);
    check("a_hs_first",  hs_first, 3);
    check("a_hs_width",  hs_cnt, 40);
    check("a_vs_cnt",    vs_cnt, 8250);
    check("a_locx_bad",  bad_x, 0);
    check("a_locy_bad",  bad_y, 0);
    check("a_hs_bad",    bad_hs, 0);
    check("a_vs_bad",    bad_vs, 0);
    check("a_de_bad",    bad_de, 0);
    check("a_lx0_k",     lx0_k, 41511);
    check("a_de_rise",   de_rise, 41513);
    check("a_de_lag",    de_rise - lx0_k, 2);
    check("a_de_fall",   de_fall, 42793);
    check("a_de_cnt",    de_cnt, 2560);
    check("a_max_x",     max_x, 1279);
    check("a_max_y",     max_y, 1);

    // Instance B: three full small frames (also exercises both wraps).
    rst_b = 1'b0;
    run_small(3, "b_frames");

    // Advance to position (h=20, v=7) of the next frame, then reset 3 clocks.
    repeat (7 * 28 + 20) tick();
    rst_b = 1'b1;
    for (int r = 0; r < 3; r++) begin
      tick();
      check("b_mid_locx",  vid_b.loc_x, 12'hFFF);
      check("b_mid_locy",  vid_b.loc_y, 12'hFFF);
      check("b_mid_de",    vid_b.de, 1'b0);
      check("b_mid_hsync", vid_b.hsync, 1'b1);
      check("b_mid_vsync", vid_b.vsync, 1'b1);
      check("b_mid_fs",    vid_b.frame_start, 1'b0);
    end
    rst_b = 1'b0;
    run_small(1, "b_restart");

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
